// File: rtl/retire_queue_pkg.sv
// Shared widths for the retire queue, renamer and write-back stage.
// Also holds small pointer/count helpers used by the queue.
package retire_queue_pkg;

  localparam int RQ_INDEX_WIDTH = 5;
  localparam int RQ_PREG_WIDTH  = 6;
  localparam int RQ_VREG_WIDTH  = 5;

  typedef enum logic [1:0] {
    OCC_HOLD = 2'b00,
    OCC_DEC  = 2'b01,
    OCC_INC  = 2'b10,
    OCC_BOTH = 2'b11
  } occ_op_t;

  function automatic occ_op_t occ_op(input logic alloc_fire, input logic retire_fire);
    return occ_op_t'({alloc_fire, retire_fire});
  endfunction

endpackage

// File: rtl/retire_out_reg.sv
// Valid/ready output register for retired entries; one-cycle load.
// Contents are held stable while presented and not accepted.
module retire_out_reg
  import retire_queue_pkg::*;
#(
  parameter int PREG_WIDTH = RQ_PREG_WIDTH,
  parameter int VREG_WIDTH = RQ_VREG_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [PREG_WIDTH-1:0] load_old_preg,
  input  logic [VREG_WIDTH-1:0] load_vreg,
  input  logic [PREG_WIDTH-1:0] load_new_preg,
  input  logic                  free_ready,
  output logic                  free_valid,
  output logic [PREG_WIDTH-1:0] free_preg,
  output logic [VREG_WIDTH-1:0] commit_vreg,
  output logic [PREG_WIDTH-1:0] commit_preg
);

  always_ff @(posedge clk) begin
    if (rst) begin
      free_valid  <= 1'b0;
      free_preg   <= '0;
      commit_vreg <= '0;
      commit_preg <= '0;
    end else if (load) begin
      free_valid  <= 1'b1;
      free_preg   <= load_old_preg;
      commit_vreg <= load_vreg;
      commit_preg <= load_new_preg;
    end else if (free_valid && free_ready) begin
      free_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/retire_queue.sv
// In-order retirement queue: records rename mappings, collects write-backs,
// retires done head entries into a valid/ready output register.
module retire_queue
  import retire_queue_pkg::*;
#(
  parameter int INDEX_WIDTH = RQ_INDEX_WIDTH,
  parameter int PREG_WIDTH  = RQ_PREG_WIDTH,
  parameter int VREG_WIDTH  = RQ_VREG_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alloc_valid,
  output logic                   alloc_ready,
  input  logic [VREG_WIDTH-1:0]  alloc_vreg,
  input  logic [PREG_WIDTH-1:0]  alloc_new_preg,
  input  logic [PREG_WIDTH-1:0]  alloc_old_preg,
  output logic [INDEX_WIDTH-1:0] alloc_index,
  input  logic                   wb_valid,
  input  logic [INDEX_WIDTH-1:0] wb_index,
  output logic                   free_valid,
  input  logic                   free_ready,
  output logic [PREG_WIDTH-1:0]  free_preg,
  output logic [VREG_WIDTH-1:0]  commit_vreg,
  output logic [PREG_WIDTH-1:0]  commit_preg,
  output logic [INDEX_WIDTH:0]   count,
  output logic                   empty
);

  localparam int DEPTH = 1 << INDEX_WIDTH;
  localparam logic [INDEX_WIDTH:0] FULL_COUNT = {1'b1, {INDEX_WIDTH{1'b0}}};

  logic [VREG_WIDTH-1:0]  vreg_q     [DEPTH];
  logic [PREG_WIDTH-1:0]  new_preg_q [DEPTH];
  logic [PREG_WIDTH-1:0]  old_preg_q [DEPTH];
  logic [DEPTH-1:0]       busy;
  logic [DEPTH-1:0]       done;
  logic [INDEX_WIDTH-1:0] head;
  logic [INDEX_WIDTH-1:0] tail;
  logic                   alloc_fire;
  logic                   retire_fire;

  // alloc_ready looks only at count so free_ready never reaches it combinationally.
  assign alloc_ready = (count != FULL_COUNT);
  assign alloc_index = tail;
  assign empty       = (count == '0);
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign retire_fire = busy[head] && done[head] && (!free_valid || free_ready);

  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      vreg_q[tail]     <= alloc_vreg;
      new_preg_q[tail] <= alloc_new_preg;
      old_preg_q[tail] <= alloc_old_preg;
    end
  end

  // Later assignments win: retire clears after write-back, allocate overrides both.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy  <= '0;
      done  <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (wb_valid && busy[wb_index]) begin
        done[wb_index] <= 1'b1;
      end
      if (retire_fire) begin
        busy[head] <= 1'b0;
        done[head] <= 1'b0;
        head       <= head + INDEX_WIDTH'(1);
      end
      if (alloc_fire) begin
        busy[tail] <= 1'b1;
        done[tail] <= 1'b0;
        tail       <= tail + INDEX_WIDTH'(1);
      end
      case (occ_op(alloc_fire, retire_fire))
        OCC_INC: count <= count + (INDEX_WIDTH + 1)'(1);
        OCC_DEC: count <= count - (INDEX_WIDTH + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  retire_out_reg #(
    .PREG_WIDTH(PREG_WIDTH),
    .VREG_WIDTH(VREG_WIDTH)
  ) u_out (
    .clk          (clk),
    .rst          (rst),
    .load         (retire_fire),
    .load_old_preg(old_preg_q[head]),
    .load_vreg    (vreg_q[head]),
    .load_new_preg(new_preg_q[head]),
    .free_ready   (free_ready),
    .free_valid   (free_valid),
    .free_preg    (free_preg),
    .commit_vreg  (commit_vreg),
    .commit_preg  (commit_preg)
  );

endmodule

// File: tb/tb_retire_queue.sv
// Directed and randomized bench for retire_queue with an in-order scoreboard model.
module tb_retire_queue;

  logic       clk = 1'b0;
  logic       rst;
  logic       alloc_valid;
  logic       alloc_ready;
  logic [4:0] alloc_vreg;
  logic [5:0] alloc_new_preg;
  logic [5:0] alloc_old_preg;
  logic [4:0] alloc_index;
  logic       wb_valid;
  logic [4:0] wb_index;
  logic       free_valid;
  logic       free_ready;
  logic [5:0] free_preg;
  logic [4:0] commit_vreg;
  logic [5:0] commit_preg;
  logic [5:0] count;
  logic       empty;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int v;
    int n;
    int o;
  } ent_t;

  ent_t exp_q[$];
  int   wb_pend[$];
  int   m_tail;

  always #5 clk = ~clk;

  retire_queue dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_vreg(alloc_vreg), .alloc_new_preg(alloc_new_preg),
    .alloc_old_preg(alloc_old_preg), .alloc_index(alloc_index),
    .wb_valid(wb_valid), .wb_index(wb_index),
    .free_valid(free_valid), .free_ready(free_ready), .free_preg(free_preg),
    .commit_vreg(commit_vreg), .commit_preg(commit_preg),
    .count(count), .empty(empty)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    alloc_valid = 1'b0; alloc_vreg = '0; alloc_new_preg = '0; alloc_old_preg = '0;
    wb_valid = 1'b0; wb_index = '0; free_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic check_reset_state(input string pfx);
    chk({pfx, "_alloc_ready"}, alloc_ready, 1);
    chk({pfx, "_empty"}, empty, 1);
    chk({pfx, "_count"}, count, 0);
    chk({pfx, "_free_valid"}, free_valid, 0);
    chk({pfx, "_alloc_index"}, alloc_index, 0);
    chk({pfx, "_free_preg"}, free_preg, 0);
    chk({pfx, "_commit_vreg"}, commit_vreg, 0);
    chk({pfx, "_commit_preg"}, commit_preg, 0);
  endtask

  task automatic alloc(input int v, input int n, input int o, input int exp_idx);
    alloc_valid = 1'b1;
    alloc_vreg = 5'(v); alloc_new_preg = 6'(n); alloc_old_preg = 6'(o);
    #1;
    chk("alloc_idx", alloc_index, exp_idx);
    tick();
    alloc_valid = 1'b0;
  endtask

  task automatic wb(input int idx);
    wb_valid = 1'b1;
    wb_index = 5'(idx);
    tick();
    wb_valid = 1'b0;
  endtask

  initial begin
    // Idle after reset
    do_reset();
    check_reset_state("rst");

    // Single entry: write-back to free_valid latency is two cycles
    alloc(3, 33, 3, 0);
    wb(0);
    chk("single_n1_valid", free_valid, 0);
    chk("single_n1_count", count, 1);
    tick();
    chk("single_n2_valid", free_valid, 1);
    chk("single_free_preg", free_preg, 3);
    chk("single_commit_vreg", commit_vreg, 3);
    chk("single_commit_preg", commit_preg, 33);
    chk("single_n2_count", count, 0);
    tick();
    chk("single_n3_valid", free_valid, 0);
    chk("single_empty", empty, 1);

    // Out-of-order write-back, in-order retire
    do_reset();
    for (int i = 0; i < 3; i++) alloc(i + 1, 40 + i, 20 + i, i);
    wb(2);
    chk("ooo_hold_a", free_valid, 0);
    wb(1);
    chk("ooo_hold_b", free_valid, 0);
    wb(0);
    chk("ooo_hold_c", free_valid, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("ooo_valid", free_valid, 1);
      chk("ooo_free_preg", free_preg, 20 + i);
      chk("ooo_commit_preg", commit_preg, 40 + i);
      tick();
    end
    chk("ooo_done_valid", free_valid, 0);

    // Fill, full, release one, wrap tail to 0
    do_reset();
    for (int i = 0; i < 32; i++) alloc(i, 32 + i, i, i);
    chk("full_count", count, 32);
    chk("full_ready", alloc_ready, 0);
    wb(0);
    chk("full_n1_ready", alloc_ready, 0);
    tick();
    chk("full_n2_ready", alloc_ready, 1);
    chk("full_n2_count", count, 31);
    chk("full_n2_valid", free_valid, 1);
    chk("full_n2_free_preg", free_preg, 0);
    alloc(7, 50, 9, 0);
    chk("wrap_count", count, 32);
    chk("wrap_ready", alloc_ready, 0);

    // Backpressure: done bits accumulate while head stalls
    do_reset();
    for (int i = 0; i < 4; i++) alloc(i, 44 + i, 10 + i, i);
    free_ready = 1'b0;
    for (int i = 0; i < 4; i++) wb(i);
    tick(); tick(); tick();
    chk("stall_valid", free_valid, 1);
    chk("stall_free_preg", free_preg, 10);
    chk("stall_count", count, 3);
    free_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("release_valid", free_valid, 1);
      chk("release_free_preg", free_preg, 10 + i);
      tick();
    end
    chk("release_end_valid", free_valid, 0);

    // Reset with a pending free and count 5
    do_reset();
    for (int i = 0; i < 6; i++) alloc(i, 20 + i, 30 + i, i);
    free_ready = 1'b0;
    wb(0);
    tick(); tick();
    chk("prerst_valid", free_valid, 1);
    chk("prerst_count", count, 5);
    rst = 1'b1;
    tick();
    check_reset_state("midrst");
    rst = 1'b0;
    free_ready = 1'b1;

    // Randomized traffic against an in-order scoreboard
    do_reset();
    exp_q.delete();
    wb_pend.delete();
    m_tail = 0;
    for (int c = 0; c < 3000; c++) begin
      alloc_valid = ($urandom_range(0, 3) != 0);
      alloc_vreg = 5'($urandom);
      alloc_new_preg = 6'($urandom);
      alloc_old_preg = 6'($urandom);
      if (wb_pend.size() > 0 && $urandom_range(0, 1) == 1) begin
        int k;
        k = $urandom_range(0, wb_pend.size() - 1);
        wb_valid = 1'b1;
        wb_index = 5'(wb_pend[k]);
        wb_pend.delete(k);
      end else begin
        wb_valid = 1'b0;
      end
      free_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (alloc_valid && alloc_ready) begin
        ent_t e;
        chk("rnd_alloc_idx", alloc_index, m_tail);
        e.v = alloc_vreg; e.n = alloc_new_preg; e.o = alloc_old_preg;
        exp_q.push_back(e);
        wb_pend.push_back(m_tail);
        m_tail = (m_tail + 1) % 32;
      end
      if (free_valid && free_ready) begin
        if (exp_q.size() == 0) begin
          chk("rnd_unexpected_free", 1, 0);
        end else begin
          ent_t e;
          e = exp_q.pop_front();
          chk("rnd_free_preg", free_preg, e.o);
          chk("rnd_commit_vreg", commit_vreg, e.v);
          chk("rnd_commit_preg", commit_preg, e.n);
        end
      end
      tick();
    end

    // Drain with a bounded budget
    alloc_valid = 1'b0;
    free_ready = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if (wb_pend.size() > 0) begin
        wb_valid = 1'b1;
        wb_index = 5'(wb_pend.pop_front());
      end else begin
        wb_valid = 1'b0;
      end
      #1;
      if (free_valid) begin
        if (exp_q.size() == 0) begin
          chk("drain_unexpected_free", 1, 0);
        end else begin
          ent_t e;
          e = exp_q.pop_front();
          chk("drain_free_preg", free_preg, e.o);
          chk("drain_commit_vreg", commit_vreg, e.v);
          chk("drain_commit_preg", commit_preg, e.n);
        end
      end
      tick();
    end
    wb_valid = 1'b0;
    chk("drain_remaining", exp_q.size(), 0);
    chk("drain_count", count, 0);
    chk("drain_empty", empty, 1);
    chk("drain_valid", free_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/retire_queue.md
# retire_queue

In-order retirement queue that sits opposite the register renamer. For each rename allocation it records the destination mapping and collects write-back completions. It retires completed entries strictly in program order, returning each displaced physical register to the free list over a valid/ready handshake and reporting the committed architectural mapping. Depth is a power of two, and the queue index travels with the instruction down to write-back.

## Interface
Parameters:
- INDEX_WIDTH, 5: log2 of queue depth; DEPTH = 1 << INDEX_WIDTH.
- PREG_WIDTH, 6: physical register index width (`PREG_BUS`).
- VREG_WIDTH, 5: architectural register index width (`VREG_BUS`).

Ports:
- clk  in  1  sole clock; all state on rising edge.
- rst  in  1  reset; synchronous, active-high.
- alloc_valid  in  1  renamer requests an entry this cycle.
- alloc_ready  out  1  entry available; allocation occurs when alloc_valid && alloc_ready.
- alloc_vreg  in  VREG_WIDTH  architectural destination.
- alloc_new_preg  in  PREG_WIDTH  newly mapped physical register.
- alloc_old_preg  in  PREG_WIDTH  previously mapped physical register, freed at retire.
- alloc_index  out  INDEX_WIDTH  tail index given to the allocating instruction; combinational from tail.
- wb_valid  in  1  write-back completion.
- wb_index  in  INDEX_WIDTH  queue index of the completing instruction.
- free_valid  out  1  retired entry presented.
- free_ready  in  1  free list accepts.
- free_preg  out  PREG_WIDTH  old physical register to recycle.
- commit_vreg  out  VREG_WIDTH  retired architectural register; valid with free_valid.
- commit_preg  out  PREG_WIDTH  committed physical mapping; valid with free_valid.
- count  out  INDEX_WIDTH+1  occupied entries, excluding the output register.
- empty  out  1  count == 0.

## Operation
- Per-entry storage: vreg, new_preg, old_preg, busy, done. Pointers: head and tail, INDEX_WIDTH bits, wrapping modulo DEPTH. The count register is one bit wider so the full and empty states are distinct.
- alloc_ready = (count != DEPTH). It does not depend on a same-cycle retire, so there is no combinational path from free_ready.
- On allocate:
  - Write the entry at tail.
  - Set busy = 1 and done = 0.
  - tail <= tail + 1.
- On write-back: if wb_valid and busy[wb_index], set done[wb_index] = 1. A write-back to an entry that is not busy is ignored.
- Write-back and allocate to the same index in one cycle: allocate wins and done ends at 0. This can only happen for an illegal stale index.
- Retire condition: busy[head] && done[head] && (!free_valid || free_ready). On retire:
  - Load the output register with {old_preg, vreg, new_preg} of the head entry.
  - Clear busy and done at head.
  - head <= head + 1.
- Output register:
  - free_valid is set on load.
  - free_valid is cleared when free_valid && free_ready and no load occurs in the same cycle.
  - Its contents are held stable while free_valid && !free_ready.
- count update: count <= count + alloc_fire − retire_fire. Simultaneous allocate and retire leaves count unchanged.
- No flush. Mispredict recovery is outside this block's scope.

## Timing
- Reset values:
  - free_valid = 0; free_preg, commit_vreg, commit_preg = 0.
  - alloc_ready = 1; alloc_index = 0; count = 0; empty = 1.
  - head = tail = 0; all busy and done bits = 0.
- Write-back to free_valid latency for the head entry:
  - wb_valid in cycle N sets done at the end of N.
  - Retire happens in N+1.
  - free_valid = 1 in N+2.
- Throughput is one retire per cycle with free_ready held high.
- free_ready low stalls retirement. The head stays put, and done bits keep accumulating.
- Full (count == DEPTH): alloc_ready = 0 from the cycle after the filling allocate. It returns to 1 the cycle after the first retire.
- Tail wrap: the allocate at tail = DEPTH−1 returns alloc_index = DEPTH−1, and the next allocation gets index 0. Head wraps the same way.
- rst asserted mid-operation: all state returns to reset values at that edge. A pending free_valid is dropped without a handshake.

## Structure
- `PREG_BUS` and `VREG_BUS` come from defines.v. Add `RQ_INDEX_BUS` there so the renamer and the write-back stage share the index width.
- One sub-module is natural: retire_out_reg, the valid/ready output register holding {free_preg, commit_vreg, commit_preg}.
- Entry arrays are flat registers indexed by pointer; no RAM macro.

## Test plan
- Reset, then check idle outputs -> alloc_ready = 1, empty = 1, count = 0, free_valid = 0, alloc_index = 0.
- Allocate (vreg 3, new 33, old 3), then wb_index 0 the next cycle, with free_ready = 1 -> free_valid is high for exactly one cycle, two cycles after the write-back. Values: free_preg = 3, commit_vreg = 3, commit_preg = 33; empty = 1 afterward.
- Allocate indices 0, 1, 2; write back 2, then 1, then 0 -> nothing retires until index 0 completes. Frees then emerge in order 0, 1, 2 on consecutive cycles.
- Fill all 32 entries -> count = 32 and alloc_ready = 0. Write back index 0 -> alloc_ready = 1 again. The next allocate returns alloc_index = 0, exercising the wrap.
- Hold free_ready = 0 with entries 0–3 done -> free_valid stays 1 with free_preg unchanged and head does not move. Release free_ready -> four frees in order.
- Assert rst while free_valid = 1 and count = 5 -> the next cycle shows all reset values.
